// File: rtl/qspi_lane_shifter.sv
// qspi_lane_shifter: 1/2/4-lane QSPI serialiser/deserialiser between controller and pads.
// Optional LSB-first wire order enabled by defining QSPI_LSB_FIRST_EN.

module qspi_lane_shifter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic [1:0]        mode_i,
  input  logic              dir_i,
  input  logic [CNT_W-1:0]  num_bits_i,
  input  logic              shift_en_i,
  input  logic              sample_en_i,
  input  logic [3:0]        io_in_i,
`ifdef QSPI_LSB_FIRST_EN
  input  logic              lsb_first_i,
`endif
  output logic [3:0]        io_out_o,
  output logic [3:0]        io_oe_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StXfer = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [1:0]        mode_q, mode_d;
  logic              dir_q, dir_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              done_q, done_d;
  logic              lsb_q;

`ifdef QSPI_LSB_FIRST_EN
  logic lsb_d;
`else
  assign lsb_q = 1'b0;
`endif

  function automatic logic [2:0] lane_cnt(input logic [1:0] m);
    case (m)
      2'b01:   lane_cnt = 3'd2;
      2'b10:   lane_cnt = 3'd4;
      default: lane_cnt = 3'd1;
    endcase
  endfunction

  logic [2:0]        lanes_q;
  logic [CNT_W-1:0]  clip_len;
  logic [CNT_W-1:0]  start_len;
  logic              act;
  logic              last;
  logic [DATA_W-1:0] sreg_shift;
  logic [DATA_W-1:0] rx_aligned;
  logic [DATA_W-1:0] ones;

  assign lanes_q = lane_cnt(mode_q);
  assign ones    = '1;
  assign act     = (state_q == StXfer) && (dir_q ? shift_en_i : sample_en_i);
  assign last    = act && (remaining_q == CNT_W'(lanes_q));

  // Bit count for a new transfer: clipped to the register width, padded to whole symbols.
  always_comb begin
    clip_len = (num_bits_i > CNT_W'(DATA_W)) ? CNT_W'(DATA_W) : num_bits_i;
    case (mode_i)
      2'b01:   start_len = (clip_len + CNT_W'(1)) & ~CNT_W'(1);
      2'b10:   start_len = (clip_len + CNT_W'(3)) & ~CNT_W'(3);
      default: start_len = clip_len;
    endcase
  end

  always_comb begin
    sreg_shift = sreg_q;
    if (dir_q) begin
      sreg_shift = lsb_q ? (sreg_q >> lanes_q) : (sreg_q << lanes_q);
    end else if (lsb_q) begin
      case (mode_q)
        2'b10:   sreg_shift = {io_in_i, sreg_q[DATA_W-1:4]};
        2'b01:   sreg_shift = {io_in_i[1:0], sreg_q[DATA_W-1:2]};
        default: sreg_shift = {io_in_i[1], sreg_q[DATA_W-1:1]};
      endcase
    end else begin
      case (mode_q)
        2'b10:   sreg_shift = {sreg_q[DATA_W-5:0], io_in_i};
        2'b01:   sreg_shift = {sreg_q[DATA_W-3:0], io_in_i[1:0]};
        default: sreg_shift = {sreg_q[DATA_W-2:0], io_in_i[1]};
      endcase
    end
  end

  // Stale transmit bits above the received field are masked off (MSB-first), or the
  // MSB-side fill is shifted down to bit 0 (LSB-first).
  assign rx_aligned = lsb_q ? (sreg_shift >> (CNT_W'(DATA_W) - len_q))
                            : (sreg_shift & ~(ones << len_q));

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    remaining_d = remaining_q;
    len_d       = len_q;
    mode_d      = mode_q;
    dir_d       = dir_q;
    rx_data_d   = rx_data_q;
    done_d      = 1'b0;
`ifdef QSPI_LSB_FIRST_EN
    lsb_d       = lsb_q;
`endif
    if (state_q == StIdle) begin
      if (start_i) begin
        sreg_d      = tx_data_i;
        mode_d      = mode_i;
        dir_d       = dir_i;
        len_d       = start_len;
        remaining_d = start_len;
`ifdef QSPI_LSB_FIRST_EN
        lsb_d       = lsb_first_i;
`endif
        if (start_len == '0) begin
          done_d = 1'b1;
        end else begin
          state_d = StXfer;
        end
      end
    end else if (act) begin
      sreg_d      = sreg_shift;
      remaining_d = remaining_q - CNT_W'(lanes_q);
      if (last) begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (!dir_q) begin
          rx_data_d = rx_aligned;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      sreg_q      <= '0;
      remaining_q <= '0;
      len_q       <= '0;
      mode_q      <= 2'b00;
      dir_q       <= 1'b0;
      rx_data_q   <= '0;
      done_q      <= 1'b0;
`ifdef QSPI_LSB_FIRST_EN
      lsb_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      remaining_q <= remaining_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      dir_q       <= dir_d;
      rx_data_q   <= rx_data_d;
      done_q      <= done_d;
`ifdef QSPI_LSB_FIRST_EN
      lsb_q       <= lsb_d;
`endif
    end
  end

  // Pad drive comes straight from registered state so the pads see no input-to-output path.
  always_comb begin
    io_out_o = 4'b0000;
    io_oe_o  = 4'b0000;
    if ((state_q == StXfer) && dir_q) begin
      case (mode_q)
        2'b10: begin
          io_oe_o  = 4'b1111;
          io_out_o = lsb_q ? sreg_q[3:0] : sreg_q[DATA_W-1 -: 4];
        end
        2'b01: begin
          io_oe_o       = 4'b0011;
          io_out_o[1:0] = lsb_q ? sreg_q[1:0] : sreg_q[DATA_W-1 -: 2];
        end
        default: begin
          io_oe_o     = 4'b0001;
          io_out_o[0] = lsb_q ? sreg_q[0] : sreg_q[DATA_W-1];
        end
      endcase
    end
  end

  assign rx_data_o = rx_data_q;
  assign busy_o    = (state_q == StXfer);
  assign done_o    = done_q;

endmodule

// File: tb/tb_qspi_lane_shifter.sv
// Self-checking bench for qspi_lane_shifter: directed cases plus randomized transfers
// checked against a symbol-level reference model.

module tb_qspi_lane_shifter;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = $clog2(DW) + 1;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          start     = 1'b0;
  logic [DW-1:0] tx_data   = '0;
  logic [1:0]    mode      = 2'b00;
  logic          dir       = 1'b0;
  logic [CW-1:0] num_bits  = '0;
  logic          shift_en  = 1'b0;
  logic          sample_en = 1'b0;
  logic [3:0]    io_in     = 4'h0;
`ifdef QSPI_LSB_FIRST_EN
  logic          lsb_first = 1'b0;
`endif
  logic [3:0]    io_out;
  logic [3:0]    io_oe;
  logic [DW-1:0] rx_data;
  logic          busy;
  logic          done;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] rx_model = '0;

  qspi_lane_shifter #(
    .DATA_W (DW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .tx_data_i   (tx_data),
    .mode_i      (mode),
    .dir_i       (dir),
    .num_bits_i  (num_bits),
    .shift_en_i  (shift_en),
    .sample_en_i (sample_en),
    .io_in_i     (io_in),
`ifdef QSPI_LSB_FIRST_EN
    .lsb_first_i (lsb_first),
`endif
    .io_out_o    (io_out),
    .io_oe_o     (io_oe),
    .rx_data_o   (rx_data),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("idle_done", 32'(done), 32'd0);
      check_eq("idle_busy", 32'(busy), 32'd0);
      check_eq("idle_oe", 32'(io_oe), 32'd0);
      check_eq("idle_rx", rx_data, rx_model);
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  // For RX, `data` is the bit stream presented on the wire in transfer order.
  task automatic run_xfer(input logic [1:0] m, input logic d, input int nb,
                          input logic [31:0] data, input logic lsb, input bit both);
    int          lanes, clip, total, nsym, gaps;
    logic [63:0] mk, wide;
    logic [31:0] sym, exp_oe;
    lanes  = (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 1;
    clip   = (nb > 32) ? 32 : nb;
    total  = ((clip + lanes - 1) / lanes) * lanes;
    nsym   = total / lanes;
    mk     = (64'd1 << lanes) - 64'd1;
    exp_oe = (lanes == 4) ? 32'hF : (lanes == 2) ? 32'h3 : 32'h1;
    wide   = {32'd0, data};

    start    = 1'b1;
    tx_data  = data;
    mode     = m;
    dir      = d;
    num_bits = CW'(nb);
`ifdef QSPI_LSB_FIRST_EN
    lsb_first = lsb;
`endif
    @(negedge clk);
    start   = 1'b0;
    tx_data = $urandom;
    check_eq("start_busy", 32'(busy), 32'(total != 0));
    check_eq("start_done", 32'(done), 32'(total == 0));

    for (int k = 0; k < nsym; k++) begin
      sym  = lsb ? 32'((wide >> (k * lanes)) & mk)
                 : 32'((wide >> (32 - (k + 1) * lanes)) & mk);
      gaps = $urandom_range(0, 2);
      for (int g = 0; g <= gaps; g++) begin
        check_eq("xfer_busy", 32'(busy), 32'd1);
        check_eq("xfer_done", 32'(done), 32'd0);
        check_eq("xfer_oe", 32'(io_oe), d ? exp_oe : 32'd0);
        check_eq("xfer_out", 32'(io_out), d ? sym : 32'd0);
        check_eq("xfer_rx_hold", rx_data, rx_model);
        io_in = 4'($urandom);
        if (g < gaps) begin
          // Non-acting cycle: wrong strobe and a stray start must both be ignored.
          if (d) sample_en = 1'($urandom);
          else   shift_en  = 1'($urandom);
          start    = 1'($urandom);
          mode     = 2'($urandom);
          dir      = 1'($urandom);
          num_bits = CW'($urandom);
          tx_data  = $urandom;
        end else begin
          if (d) begin
            shift_en  = 1'b1;
            sample_en = both ? 1'b1 : 1'($urandom);
          end else begin
            sample_en = 1'b1;
            shift_en  = both ? 1'b1 : 1'($urandom);
            case (lanes)
              4:       io_in = sym[3:0];
              2:       io_in[1:0] = sym[1:0];
              default: io_in[1] = sym[0];
            endcase
          end
        end
        @(negedge clk);
        shift_en  = 1'b0;
        sample_en = 1'b0;
        start     = 1'b0;
      end
    end

    if (!d && total != 0) begin
      rx_model = lsb ? 32'(wide & ((64'd1 << total) - 64'd1))
                     : 32'(wide >> (32 - total));
    end
    check_eq("end_done", 32'(done), 32'd1);
    check_eq("end_busy", 32'(busy), 32'd0);
    check_eq("end_oe", 32'(io_oe), 32'd0);
    check_eq("end_out", 32'(io_out), 32'd0);
    check_eq("end_rx", rx_data, rx_model);
  endtask

  initial begin
    logic [1:0]  rm;
    logic        rd, rl;
    int          rn;
    logic [31:0] rdat;

    repeat (2) @(negedge clk);
    check_eq("rst_out", 32'(io_out), 32'd0);
    check_eq("rst_oe", 32'(io_oe), 32'd0);
    check_eq("rst_rx", rx_data, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    idle(2);

    run_xfer(2'b10, 1'b1, 32, 32'hA5C3_0F96, 1'b0, 1'b0);
    idle(1);
    run_xfer(2'b00, 1'b0, 8, 32'hB200_0000, 1'b0, 1'b0);
    check_eq("rx_b2", rx_data, 32'h0000_00B2);
    idle(1);
    run_xfer(2'b01, 1'b1, 6, $urandom, 1'b0, 1'b1);
    idle(1);
    run_xfer(2'b00, 1'b1, 0, $urandom, 1'b0, 1'b0);
    idle(2);
    run_xfer(2'b00, 1'b0, 40, $urandom, 1'b0, 1'b0);
    idle(1);
    run_xfer(2'b10, 1'b1, 5, $urandom, 1'b0, 1'b0);
    idle(1);
    run_xfer(2'b11, 1'b0, 7, $urandom, 1'b0, 1'b0);
    idle(1);

    // Back-to-back: the second start lands in the first transfer's done cycle.
    run_xfer(2'b10, 1'b0, 12, $urandom, 1'b0, 1'b0);
    run_xfer(2'b01, 1'b1, 10, $urandom, 1'b0, 1'b0);
    run_xfer(2'b00, 1'b0, 3, $urandom, 1'b0, 1'b0);
    idle(1);

    // Asynchronous reset in the middle of a quad transmit.
    start    = 1'b1;
    tx_data  = $urandom;
    mode     = 2'b10;
    dir      = 1'b1;
    num_bits = CW'(32);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      shift_en = 1'b1;
      @(negedge clk);
      shift_en = 1'b0;
    end
    check_eq("prerst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    rx_model = '0;
    check_eq("arst_out", 32'(io_out), 32'd0);
    check_eq("arst_oe", 32'(io_oe), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_done", 32'(done), 32'd0);
    check_eq("arst_rx", rx_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

`ifdef QSPI_LSB_FIRST_EN
    run_xfer(2'b10, 1'b1, 32, 32'h0000_0021, 1'b1, 1'b0);
    idle(1);
    run_xfer(2'b01, 1'b0, 14, $urandom, 1'b1, 1'b0);
    idle(1);
`endif

    for (int t = 0; t < 40; t++) begin
      rm   = 2'($urandom);
      rd   = 1'($urandom);
      rn   = $urandom_range(0, 40);
      rdat = $urandom;
`ifdef QSPI_LSB_FIRST_EN
      rl   = 1'($urandom);
`else
      rl   = 1'b0;
`endif
      run_xfer(rm, rd, rn, rdat, rl, 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/qspi_lane_shifter.md
# qspi_lane_shifter

Parametrised bidirectional QSPI data shifter that serialises transmit words and deserialises receive words over 1, 2 or 4 IO lanes with a programmable bit count. It sits between the controller FSM/FIFOs and the pad layer. It is strobed by the SCLK generator's drive and sample strobes. It drives explicit per-lane output enables; it never drives `z` itself.

## Interface
- `DATA_W`, 32: shift register width; must be a multiple of 4 and at least 8.
- `CNT_W`, `$clog2(DATA_W)+1`: width of bit-count fields (derived; do not override).

- `clk`  in  1  system clock (HCLK).
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin transfer; sampled only in IDLE.
- `tx_data`  in  DATA_W  transmit word, MSB-first; latched on accepted `start`.
- `mode`  in  2  lane mode: 00 single, 01 dual, 10 quad, 11 treated as single; latched on `start`.
- `dir`  in  1  1 = transmit, 0 = receive; latched on `start`.
- `num_bits`  in  CNT_W  bits to transfer; latched on `start`.
- `shift_en`  in  1  drive-edge strobe from SCLK generator.
- `sample_en`  in  1  sample-edge strobe from SCLK generator.
- `io_in`  in  4  pad input values IO[3:0].
- `io_out`  out  4  pad output values IO[3:0].
- `io_oe`  out  4  pad output enables, 1 = drive.
- `rx_data`  out  DATA_W  last received word, right-aligned.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, XFER. Lane count L = 1/2/4 from the latched `mode`.
- On accepting `start` in IDLE:
  - Latch `tx_data` into `sreg`, and latch `mode` and `dir`.
  - Set `remaining` = min(`num_bits`, DATA_W) rounded up to a multiple of L.
  - Go to XFER.
  - If `remaining` = 0, stay in IDLE and pulse `done` next cycle; `rx_data` is unchanged.
- TX in XFER:
  - Quad: `io_out[3:0]` = `sreg[W-1:W-4]`.
  - Dual: `io_out[1:0]` = `sreg[W-1:W-2]`.
  - Single: `io_out[0]` = `sreg[W-1]`.
  - Unused lanes drive 0 with oe=0.
  - `io_oe` = 0001 / 0011 / 1111 for single / dual / quad.
  - Each `shift_en` shifts `sreg` left by L with zero fill and decrements `remaining` by L.
- RX in XFER:
  - `io_oe` = 0000.
  - Each `sample_en` shifts `sreg` left by L, filling the LSBs from the lanes:
    - single: `io_in[1]` (MISO)
    - dual: {`io_in[1]`, `io_in[0]`}
    - quad: `io_in[3:0]`
  - Each `sample_en` decrements `remaining` by L.
- Only the strobe matching `dir` acts. The other strobe is ignored, including when both assert in the same cycle.
- Completion: the strobe that brings `remaining` to 0 returns the FSM to IDLE.
  - RX: `rx_data` is loaded with the received bits in `[n-1:0]`, upper bits zero.
  - `rx_data` holds until the next RX completion.
- `start` during XFER is ignored. No abort input; reset is the only abort.

## Timing
- Reset values: state IDLE, `sreg`=0, `remaining`=0, `io_out`=0, `io_oe`=0, `rx_data`=0, `busy`=0, `done`=0.
- All outputs are registered or derived from registered state only; there is no combinational path from inputs.
- `busy` = 1 from the cycle after the accepted `start` until the cycle after the final strobe.
- TX: the first symbol appears on `io_out`/`io_oe` the cycle after `start`, before the first `shift_en`.
- `done` is high exactly one cycle: the cycle after the final strobe. In that cycle `busy`=0 and `io_oe`=0, and `rx_data` is already valid.
- A new `start` in the `done` cycle is accepted (back-to-back transfers).
- Asynchronous reset mid-transfer clears all state immediately. No `done` is issued.

## Configuration
- `QSPI_LSB_FIRST_EN`:
  - Defined: adds input `lsb_first` (1 bit, latched on `start`). When it is 1, TX takes lanes from `sreg[L-1:0]` and shifts right. RX fills from the MSB side and right-aligns on completion, giving LSB-first bit order on the wire.
  - Undefined: the port is absent and operation is MSB-first only.

## Test plan
- Quad TX: `tx_data`=32'hA5C3_0F96, `num_bits`=32, 8 `shift_en` -> `io_out` sequence A,5,C,3,0,F,9,6; `io_oe`=1111 throughout; `done` pulses once, one cycle after the 8th strobe.
- Single RX: `mode`=00, `num_bits`=8, `io_in[1]` driving 1,0,1,1,0,0,1,0 on successive `sample_en` -> `rx_data`=32'h0000_00B2; `io_oe`=0000 throughout.
- Dual TX: `num_bits`=6 with 3 `shift_en`, plus `sample_en` pulsed concurrently -> `io_oe`=0011; the extra strobes are ignored; `done` follows the 3rd `shift_en`.
- Boundaries:
  - `num_bits`=0 -> `done` next cycle, `busy` never set.
  - Single mode, `num_bits`=40, DATA_W=32 -> exactly 32 strobes to complete.
  - Quad, `num_bits`=5 -> rounded to 8, 2 strobes.
- `start` while busy is ignored; `rst_n` low mid-quad-TX -> all outputs 0 immediately and no `done`; back-to-back `start` in the `done` cycle is accepted.
- With `QSPI_LSB_FIRST_EN` and `lsb_first`=1, quad TX of 32'h0000_0021 -> `io_out` 1,2,0,0,0,0,0,0.
